sm_scoreboard: RTL

//   SM-level register/predicate scoreboard between decode (ID) and the SP-core lanes. Reserves destination

---
 rtl/sm_scoreboard_pkg.sv | 35 +++
 rtl/sm_scoreboard_reg_counter.sv | 42 ++++
 rtl/sm_scoreboard.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sm_scoreboard_pkg.sv
// rtl/sm_scoreboard_pkg.sv - scoreboard sizing constants and register-mask helpers
package sm_scoreboard_pkg;

   localparam int SB_CNT_W    = 2;
   localparam int SB_NUM_GPR  = 16;
   localparam int SB_NUM_PRED = 4;
   localparam int SB_GPR_AW   = 4;
   localparam int SB_PRED_AW  = 2;

   // WMMA quads are aligned to four registers; the low two address bits are dropped
   localparam logic [SB_GPR_AW-1:0] SB_QUAD_BASE_MASK = 4'b1100;

   function automatic logic [SB_NUM_GPR-1:0] onehot_gpr(input logic [SB_GPR_AW-1:0] a);
      logic [SB_NUM_GPR-1:0] m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

   function automatic logic [SB_NUM_PRED-1:0] onehot_pred(input logic [SB_PRED_AW-1:0] a);
      logic [SB_NUM_PRED-1:0] m;
      m    = '0;
      m[a] = 1'b1;
      return m;
   endfunction

   function automatic logic [SB_NUM_GPR-1:0] quad_mask(input logic [SB_GPR_AW-1:0] a);
      logic [SB_GPR_AW-1:0]  base;
      logic [SB_NUM_GPR-1:0] m;
      base = a & SB_QUAD_BASE_MASK;
      m    = {{(SB_NUM_GPR-4){1'b0}}, 4'hF};
      return m << base;
   endfunction

endpackage

// File: rtl/sm_scoreboard_reg_counter.sv
// rtl/sm_scoreboard_reg_counter.sv - per-GPR pending-write up/down counter
module sm_scoreboard_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inc,
   input  logic [1:0] dec,
   output logic       busy,
   output logic       full,
   output logic       underflow
);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   sum, dec_ext, diff;

   // net change of reserve and releases; releasing more than is pending clamps at zero
   always_comb begin
      sum       = {1'b0, cnt_q} + {{CNT_W{1'b0}}, inc};
      dec_ext   = {{(CNT_W-1){1'b0}}, dec};
      diff      = sum - dec_ext;
      cnt_d     = diff[CNT_W-1:0];
      underflow = 1'b0;
      if (sum < dec_ext) begin
         cnt_d     = '0;
         underflow = 1'b1;
      end
   end

   // counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy = |cnt_q;
   assign full = &cnt_q;

endmodule

// File: rtl/sm_scoreboard.sv
// rtl/sm_scoreboard.sv - SM register/predicate scoreboard between ID and SP lanes
module sm_scoreboard
   import sm_scoreboard_pkg::*;
#(
   parameter int CNT_W = SB_CNT_W
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        issue_valid,
   input  logic [3:0]  issue_rs0_addr,
   input  logic [3:0]  issue_rs1_addr,
   input  logic [3:0]  issue_rs2_addr,
   input  logic [2:0]  issue_rs_use,
   input  logic        issue_pred_use,
   input  logic [1:0]  issue_pred_rd_sel,
   input  logic        issue_rf_we,
   input  logic [3:0]  issue_rD_addr,
   input  logic        issue_wmma,
   input  logic        issue_pred_we,
   input  logic [1:0]  issue_pred_wr_sel,
   input  logic        pipe_stall,
   input  logic        flush_id,
   input  logic        wb_valid,
   input  logic        wb_rf_we,
   input  logic [3:0]  wb_rD_addr,
   input  logic        wb_pred_we,
   input  logic [1:0]  wb_pred_wr_sel,
   input  logic        wmma_done,
   input  logic [3:0]  wmma_base,
   output logic        hazard_stall,
   output logic        issue_fire,
   output logic [15:0] gpr_busy,
   output logic [3:0]  pred_busy,
   output logic        sb_empty,
   output logic        sb_err
);

   logic [SB_NUM_GPR-1:0]  dst_mask, inc_vec, wb_hit, wmma_hit;
   logic [SB_NUM_GPR-1:0]  cnt_busy, cnt_full, cnt_uflow;
   logic [SB_NUM_PRED-1:0] pred_busy_q, pred_busy_d, pred_set, pred_clr;
   logic                   pred_uflow, sb_err_q, sb_err_d;
   logic                   raw, waw, rel;

   // WB is frozen while the pipe stalls, so a held WB must only release once
   assign rel = wb_valid & ~pipe_stall;

   // destination set of the ID instruction and the registers released this cycle
   always_comb begin
      dst_mask = '0;
      if (issue_wmma) begin
         dst_mask = quad_mask(issue_rD_addr);
      end else if (issue_rf_we) begin
         dst_mask = onehot_gpr(issue_rD_addr);
      end
      wb_hit = '0;
      if (rel && wb_rf_we) begin
         wb_hit = onehot_gpr(wb_rD_addr);
      end
      wmma_hit = '0;
      if (wmma_done) begin
         wmma_hit = quad_mask(wmma_base);
      end
   end

   // hazards look at registered state only; a release becomes readable the next cycle
   always_comb begin
      raw = (issue_rs_use[0] & cnt_busy[issue_rs0_addr])
          | (issue_rs_use[1] & cnt_busy[issue_rs1_addr])
          | (issue_rs_use[2] & cnt_busy[issue_rs2_addr])
          | (issue_pred_use  & pred_busy_q[issue_pred_rd_sel]);
      waw = (|(dst_mask & cnt_full))
          | (issue_pred_we & pred_busy_q[issue_pred_wr_sel]);
   end

   assign hazard_stall = issue_valid & (raw | waw);
   assign issue_fire   = issue_valid & ~hazard_stall & ~pipe_stall & ~flush_id;
   assign inc_vec      = issue_fire ? dst_mask : '0;

   for (genvar g = 0; g < SB_NUM_GPR; g++) begin : g_cnt
      sm_scoreboard_reg_counter #(
         .CNT_W     (CNT_W)
      ) u_cnt (
         .clk       (clk),
         .rst       (rst),
         .inc       (inc_vec[g]),
         .dec       ({wb_hit[g] & wmma_hit[g], wb_hit[g] ^ wmma_hit[g]}),
         .busy      (cnt_busy[g]),
         .full      (cnt_full[g]),
         .underflow (cnt_uflow[g])
      );
   end

   // predicate reservations: one outstanding writer each; set and clear together cancel
   always_comb begin
      pred_set    = (issue_fire && issue_pred_we) ? onehot_pred(issue_pred_wr_sel) : '0;
      pred_clr    = (rel && wb_pred_we) ? onehot_pred(wb_pred_wr_sel) : '0;
      pred_busy_d = pred_busy_q;
      pred_uflow  = 1'b0;
      for (int p = 0; p < SB_NUM_PRED; p++) begin
         if (pred_set[p] && !pred_clr[p]) begin
            pred_busy_d[p] = 1'b1;
         end else if (pred_clr[p] && !pred_set[p]) begin
            pred_busy_d[p] = 1'b0;
            if (!pred_busy_q[p]) begin
               pred_uflow = 1'b1;
            end
         end
      end
      sb_err_d = sb_err_q | pred_uflow | (|cnt_uflow);
   end

   // predicate busy bits and sticky release-error flag
   always_ff @(posedge clk) begin
      if (rst) begin
         pred_busy_q <= '0;
         sb_err_q    <= 1'b0;
      end else begin
         pred_busy_q <= pred_busy_d;
         sb_err_q    <= sb_err_d;
      end
   end

   assign gpr_busy  = cnt_busy;
   assign pred_busy = pred_busy_q;
   assign sb_empty  = ~(|cnt_busy) & ~(|pred_busy_q);
   assign sb_err    = sb_err_q;

endmodule
